// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, reads instruction memory over req/ack,
// and hands each instruction plus its PC+4 to decode under valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             CLK,
    input  logic             RST,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      Ins,
    output logic [31:0]      nextPC,
    output logic             ins_valid,
    input  logic             ins_ready,
    input  logic             redirect,
    input  logic [31:0]      newPC,
    output logic             misalign,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic {S_FETCH, S_HOLD} state_t;

    localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic               drop_q, drop_d;
    logic               req_q, req_d;
    logic [31:0]        ins_q, ins_d;
    logic [31:0]        npc_q, npc_d;
    logic               valid_q, valid_d;
    logic               mis_q, mis_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        pc_inc;
    logic [31:0]        target;
    logic               acked;
    logic               accept;

    assign pc_inc = pc_q + 32'd4;
    assign target = {newPC[31:2], 2'b00};
    assign acked  = req_q && imem_ack;
    assign accept = valid_q && ins_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        ins_d   = ins_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_FETCH: begin
                if (acked) begin
                    // Data is stale if a redirect arrived earlier or arrives now.
                    if (drop_q || redirect) begin
                        drop_d = 1'b0;
                    end else begin
                        ins_d   = imem_rdata;
                        npc_d   = pc_inc;
                        pc_d    = pc_inc;
                        valid_d = 1'b1;
                        state_d = S_HOLD;
                    end
                end else if (redirect && req_q) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (redirect) begin
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (redirect) begin
            pc_d = target;
        end

        mis_d = redirect && (newPC[1:0] != 2'b00);
        req_d = (state_d == S_FETCH);

        // The address only moves when a fresh request starts; an outstanding
        // request keeps its address until the memory acks it.
        if (req_d && (!req_q || acked)) begin
            addr_d = {pc_d[31:2], 2'b00};
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC_AL;
            addr_q  <= RESET_PC_AL;
            drop_q  <= 1'b0;
            req_q   <= 1'b0;
            ins_q   <= 32'd0;
            npc_q   <= 32'd0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            drop_q  <= drop_d;
            req_q   <= req_d;
            ins_q   <= ins_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign Ins       = ins_q;
    assign nextPC    = npc_q;
    assign ins_valid = valid_q;
    assign misalign  = mis_q;
    assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a wait-programmable memory model answers requests and a
// queue of expected (Ins, nextPC) pairs is compared at each decode handshake.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imem_req, imem_ack, ins_valid, ins_ready, redirect, misalign;
    logic [31:0] imem_addr, imem_rdata, Ins, nextPC, newPC, fetch_cnt;

    int          mem_wait;
    logic        mem_en;
    int          wcnt;

    typedef struct {
        logic [31:0] ins;
        logic [31:0] npc;
    } exp_t;

    exp_t        sbq[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_cnt;

    always #5 CLK = ~CLK;

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .Ins(Ins), .nextPC(nextPC), .ins_valid(ins_valid), .ins_ready(ins_ready),
        .redirect(redirect), .newPC(newPC), .misalign(misalign), .fetch_cnt(fetch_cnt)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0000;
    endfunction

    // Memory acks combinationally once the request has waited mem_wait cycles.
    assign imem_ack   = imem_req && mem_en && (wcnt >= mem_wait);
    assign imem_rdata = mem_word(imem_addr);

    always @(posedge CLK or negedge RST) begin
        if (!RST) wcnt <= 0;
        else if (imem_req && !imem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.ins = mem_word(pc);
        e.npc = pc + 32'd4;
        sbq.push_back(e);
    endtask

    task automatic do_reset(input int w, input logic rdy);
        RST = 1'b0; redirect = 1'b0; newPC = 32'd0;
        ins_ready = rdy; mem_wait = w; mem_en = 1'b1;
        sbq.delete(); model_cnt = 32'd0;
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        RST = 1'b0; redirect = 1'b0; newPC = 32'd0; ins_ready = 1'b0;
        mem_wait = 0; mem_en = 1'b1;
        repeat (2) @(negedge CLK);
        checks++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b0 || misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl req=%b valid=%b mis=%b required 0 0 0", imem_req, ins_valid, misalign);
        end
        checks++;
        if (Ins !== 32'd0 || nextPC !== 32'd0 || fetch_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_data Ins=%h nextPC=%h cnt=%0d required 0 0 0", Ins, nextPC, fetch_cnt);
        end
        RST = 1'b1;
        @(posedge CLK); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            failures++;
            $display("FAIL reset_first_req req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        @(negedge CLK);
    endtask

    task automatic test_stream;
        exp_t e;
        int   last_acc;
        do_reset(0, 1'b1);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC);
        last_acc = -1;
        for (int c = 0; c < 30 && sbq.size() > 0; c++) begin
            if (ins_valid && ins_ready) begin
                e = sbq.pop_front();
                checks++;
                if (Ins !== e.ins || nextPC !== e.npc) begin
                    failures++;
                    $display("FAIL stream_data Ins=%h nextPC=%h required %h %h", Ins, nextPC, e.ins, e.npc);
                end
                model_cnt++;
                if (last_acc >= 0) begin
                    checks++;
                    if (c - last_acc != 2) begin
                        failures++;
                        $display("FAIL stream_rate spacing=%0d required 2", c - last_acc);
                    end
                end
                last_acc = c;
            end
            @(negedge CLK);
        end
        checks++;
        if (sbq.size() != 0 || fetch_cnt !== model_cnt) begin
            failures++;
            $display("FAIL stream_done pending=%0d cnt=%0d required 0 %0d", sbq.size(), fetch_cnt, model_cnt);
        end
    endtask

    task automatic test_wait;
        exp_t e;
        int   waits;
        do_reset(3, 1'b0);
        waits = 0;
        for (int c = 0; c < 20 && !ins_valid; c++) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
                failures++;
                $display("FAIL wait_addr req=%b addr=%h required 1 00000000", imem_req, imem_addr);
            end
            if (!imem_ack) waits++;
            @(negedge CLK);
        end
        checks++;
        if (ins_valid !== 1'b1 || waits != 3) begin
            failures++;
            $display("FAIL wait_latency valid=%b waits=%0d required 1 3", ins_valid, waits);
        end
        push_exp(32'h0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (ins_valid !== 1'b1 || Ins !== mem_word(32'h0) || nextPC !== 32'h4 || fetch_cnt !== 32'd0) begin
                failures++;
                $display("FAIL wait_hold valid=%b Ins=%h nextPC=%h cnt=%0d required 1 %h 00000004 0",
                         ins_valid, Ins, nextPC, fetch_cnt, mem_word(32'h0));
            end
            @(negedge CLK);
        end
        ins_ready = 1'b1;
        e = sbq.pop_front();
        checks++;
        if (ins_valid !== 1'b1 || Ins !== e.ins || nextPC !== e.npc) begin
            failures++;
            $display("FAIL wait_accept valid=%b Ins=%h nextPC=%h required 1 %h %h", ins_valid, Ins, nextPC, e.ins, e.npc);
        end
        @(negedge CLK);
        ins_ready = 1'b0;
        checks++;
        if (fetch_cnt !== 32'd1 || ins_valid !== 1'b0) begin
            failures++;
            $display("FAIL wait_count cnt=%0d valid=%b required 1 0", fetch_cnt, ins_valid);
        end
    endtask

    task automatic test_redirect_drop(input bit b2b);
        exp_t        e;
        logic [31:0] tgt;
        logic [31:0] first_new;
        do_reset(2, 1'b1);
        push_exp(32'h0); push_exp(32'h4);
        for (int c = 0; c < 30 && sbq.size() > 0; c++) begin
            if (ins_valid && ins_ready) begin
                e = sbq.pop_front();
                checks++;
                if (Ins !== e.ins || nextPC !== e.npc) begin
                    failures++;
                    $display("FAIL drop_pre Ins=%h nextPC=%h required %h %h", Ins, nextPC, e.ins, e.npc);
                end
                model_cnt++;
            end
            @(negedge CLK);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8 || imem_ack !== 1'b0) begin
            failures++;
            $display("FAIL drop_outstanding req=%b addr=%h ack=%b required 1 00000008 0", imem_req, imem_addr, imem_ack);
        end
        redirect = 1'b1; newPC = 32'h40;
        @(negedge CLK);
        if (b2b) begin
            newPC = 32'h60;
            @(negedge CLK);
        end
        redirect = 1'b0;
        tgt = b2b ? 32'h60 : 32'h40;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL drop_addr_stable req=%b addr=%h required 1 00000008", imem_req, imem_addr);
        end
        push_exp(tgt);
        first_new = 32'hFFFF_FFFF;
        for (int c = 0; c < 30 && sbq.size() > 0; c++) begin
            if (imem_req && imem_addr != 32'h8 && first_new == 32'hFFFF_FFFF) first_new = imem_addr;
            if (ins_valid && ins_ready) begin
                e = sbq.pop_front();
                checks++;
                if (Ins !== e.ins || nextPC !== e.npc) begin
                    failures++;
                    $display("FAIL drop_post Ins=%h nextPC=%h required %h %h", Ins, nextPC, e.ins, e.npc);
                end
                model_cnt++;
            end
            @(negedge CLK);
        end
        checks++;
        if (sbq.size() != 0 || first_new !== tgt || fetch_cnt !== model_cnt) begin
            failures++;
            $display("FAIL drop_done pending=%0d next_addr=%h cnt=%0d required 0 %h %0d",
                     sbq.size(), first_new, fetch_cnt, tgt, model_cnt);
        end
    endtask

    task automatic test_redirect_accept;
        exp_t e;
        do_reset(0, 1'b1);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8); push_exp(32'hC); push_exp(32'h10);
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            redirect = 1'b0;
            if (ins_valid && ins_ready) begin
                e = sbq.pop_front();
                checks++;
                if (Ins !== e.ins || nextPC !== e.npc) begin
                    failures++;
                    $display("FAIL racc_data Ins=%h nextPC=%h required %h %h", Ins, nextPC, e.ins, e.npc);
                end
                model_cnt++;
                if (nextPC == 32'h14) begin
                    redirect = 1'b1; newPC = 32'h80;
                end
            end
            @(negedge CLK);
        end
        redirect = 1'b0;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h80 || fetch_cnt !== 32'd5) begin
            failures++;
            $display("FAIL racc_target req=%b addr=%h cnt=%0d required 1 00000080 5", imem_req, imem_addr, fetch_cnt);
        end
        push_exp(32'h80);
        for (int c = 0; c < 10 && sbq.size() > 0; c++) begin
            if (ins_valid && ins_ready) begin
                e = sbq.pop_front();
                checks++;
                if (Ins !== e.ins || nextPC !== e.npc) begin
                    failures++;
                    $display("FAIL racc_post Ins=%h nextPC=%h required %h %h", Ins, nextPC, e.ins, e.npc);
                end
                model_cnt++;
            end
            @(negedge CLK);
        end
        checks++;
        if (sbq.size() != 0 || fetch_cnt !== 32'd6) begin
            failures++;
            $display("FAIL racc_done pending=%0d cnt=%0d required 0 6", sbq.size(), fetch_cnt);
        end
    endtask

    task automatic test_misalign_wrap;
        exp_t e;
        do_reset(0, 1'b0);
        @(negedge CLK);
        redirect = 1'b1; newPC = 32'h0000_0102;
        @(negedge CLK);
        redirect = 1'b0;
        checks++;
        if (misalign !== 1'b1 || ins_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL mis_pulse mis=%b valid=%b req=%b addr=%h required 1 0 1 00000100",
                     misalign, ins_valid, imem_req, imem_addr);
        end
        @(negedge CLK);
        checks++;
        if (misalign !== 1'b0 || ins_valid !== 1'b1 || Ins !== mem_word(32'h100) || nextPC !== 32'h104) begin
            failures++;
            $display("FAIL mis_fetch mis=%b valid=%b Ins=%h nextPC=%h required 0 1 %h 00000104",
                     misalign, ins_valid, Ins, nextPC, mem_word(32'h100));
        end
        redirect = 1'b1; newPC = 32'hFFFF_FFFC;
        @(negedge CLK);
        redirect = 1'b0;
        checks++;
        if (misalign !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_addr mis=%b addr=%h required 0 fffffffc", misalign, imem_addr);
        end
        push_exp(32'hFFFF_FFFC);
        @(negedge CLK);
        ins_ready = 1'b1;
        e = sbq.pop_front();
        checks++;
        if (ins_valid !== 1'b1 || Ins !== e.ins || nextPC !== e.npc) begin
            failures++;
            $display("FAIL wrap_data valid=%b Ins=%h nextPC=%h required 1 %h %h", ins_valid, Ins, nextPC, e.ins, e.npc);
        end
        @(negedge CLK);
        ins_ready = 1'b0;
        checks++;
        if (fetch_cnt !== 32'd1 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL wrap_next cnt=%0d req=%b addr=%h required 1 1 00000000", fetch_cnt, imem_req, imem_addr);
        end
    endtask

    task automatic test_reset_midwait;
        exp_t e;
        do_reset(0, 1'b1);
        push_exp(32'h0); push_exp(32'h4); push_exp(32'h8);
        for (int c = 0; c < 30 && sbq.size() > 0; c++) begin
            if (ins_valid && ins_ready) begin
                e = sbq.pop_front();
                checks++;
                if (Ins !== e.ins || nextPC !== e.npc) begin
                    failures++;
                    $display("FAIL rmid_data Ins=%h nextPC=%h required %h %h", Ins, nextPC, e.ins, e.npc);
                end
                if (sbq.size() == 0) mem_wait = 5;
            end
            @(negedge CLK);
        end
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hC || fetch_cnt !== 32'd3) begin
            failures++;
            $display("FAIL rmid_pre req=%b addr=%h cnt=%0d required 1 0000000c 3", imem_req, imem_addr, fetch_cnt);
        end
        #2 RST = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || ins_valid !== 1'b0 || fetch_cnt !== 32'd0) begin
            failures++;
            $display("FAIL rmid_clear req=%b valid=%b cnt=%0d required 0 0 0", imem_req, ins_valid, fetch_cnt);
        end
        @(negedge CLK);
        RST = 1'b1; mem_wait = 0;
        @(posedge CLK); #1;
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            failures++;
            $display("FAIL rmid_restart req=%b addr=%h required 1 00000000", imem_req, imem_addr);
        end
        push_exp(32'h0);
        @(negedge CLK);
        @(negedge CLK);
        e = sbq.pop_front();
        checks++;
        if (ins_valid !== 1'b1 || Ins !== e.ins || nextPC !== e.npc) begin
            failures++;
            $display("FAIL rmid_first valid=%b Ins=%h nextPC=%h required 1 %h %h", ins_valid, Ins, nextPC, e.ins, e.npc);
        end
    endtask

    initial begin
        RST = 1'b0; redirect = 1'b0; newPC = 32'd0; ins_ready = 1'b0;
        mem_wait = 0; mem_en = 1'b1; model_cnt = 32'd0;
        test_reset;
        test_stream;
        test_wait;
        test_redirect_drop(1'b0);
        test_redirect_drop(1'b1);
        test_redirect_accept;
        test_misalign_wrap;
        test_reset_midwait;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the MIPS pipeline. It is the producer end of the `Ins`/`nextPC` interface consumed by decode/EX, and the consumer of the `newPC` redirect that EX produces.
- Holds the PC and issues word reads to instruction memory over a req/ack handshake.
- Presents each fetched instruction with its PC+4 under a valid/ready handshake.
- Accepts redirects and squashes stale fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- CNT_W, 32, width of the retired-fetch counter.

Ports:
- CLK  in  1  clock, all state on posedge.
- RST  in  1  asynchronous, active-low reset.
- imem_req  out  1  instruction read request.
- imem_addr  out  32  byte address of request; bits [1:0] always 00.
- imem_ack  in  1  read complete; imem_rdata valid this cycle.
- imem_rdata  in  32  instruction word.
- Ins  out  32  instruction delivered to decode.
- nextPC  out  32  PC of Ins plus 4.
- ins_valid  out  1  Ins/nextPC valid.
- ins_ready  in  1  decode accepts Ins this cycle.
- redirect  in  1  load newPC as next fetch address (branch/jump taken or JR).
- newPC  in  32  redirect target from EX.
- misalign  out  1  one-cycle pulse: redirect target had nonzero [1:0].
- fetch_cnt  out  CNT_W  number of completed ins_valid&&ins_ready handshakes.

Behaviour:
- Reset (RST=0, async) forces these values:
  - pc=RESET_PC, state=FETCH, drop=0.
  - imem_req=0, ins_valid=0, Ins=0, nextPC=0, misalign=0, fetch_cnt=0.
  - imem_req rises on the first posedge after RST deasserts.
- States:
  - FETCH: request outstanding.
  - HOLD: instruction held for decode.
- FETCH:
  - imem_req=1, imem_addr={pc[31:2],2'b00}.
  - Address is stable until ack; req never drops without ack.
  - imem_ack sampled at posedge. Ack in the same cycle as the first req cycle is legal (zero-wait memory → 1-cycle fetch latency).
  - On ack with drop=0: Ins<=imem_rdata, nextPC<=pc+4, pc<=pc+4, ins_valid<=1, imem_req<=0, go HOLD.
  - On ack with drop=1: discard data, drop<=0, stay FETCH. Next request uses the current pc, which is already the redirect target.
- HOLD:
  - ins_valid=1; Ins/nextPC stable until accepted.
  - On ins_valid&&ins_ready: fetch_cnt++, ins_valid<=0, go FETCH. The next request is issued the following cycle.
- Redirect (sampled at posedge, any state):
  - pc <= {newPC[31:2],2'b00}.
  - misalign pulses for 1 cycle if newPC[1:0]!=0.
  - In FETCH with no ack that cycle: drop<=1. imem_addr stays at the old address until ack, then the request is reissued at the new pc.
  - In FETCH with ack the same cycle: data discarded, stay FETCH with the new pc, drop stays 0.
  - In HOLD without ins_ready: held instruction killed (ins_valid<=0), go FETCH.
  - In HOLD with ins_ready the same cycle: handshake completes (delay-slot instruction delivered, counted), then FETCH at the new pc.
- Back-to-back redirects: the last one wins; drop stays 1 until the single outstanding ack returns.
- Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC → 0). fetch_cnt wraps modulo 2^CNT_W.
- At most one request outstanding; no prefetch.
- Throughput: one instruction per 2 cycles with zero-wait memory.

Test Plan:
1. Reset release with RESET_PC=0 and an ack-always memory returning word=addr → first imem_addr=0. Ins=0 with nextPC=4, then Ins=4 with nextPC=8, one every 2 cycles. fetch_cnt increments per accept.
2. Memory acks after 3 wait cycles while ins_ready=0 for 5 cycles → imem_addr stable during the wait. Ins held stable with ins_valid=1 until ready, exactly one fetch_cnt increment.
3. Redirect to 32'h0000_0040 while a request to 8 is outstanding → data for 8 dropped, next req at 0x40, delivered nextPC=0x44, no ins_valid for address 8.
4. Redirect coincident with accept in HOLD (Ins from pc 0x10) → 0x10 instruction counted. Next fetch at the target, not 0x14.
5. Redirect to 32'h0000_0102 → misalign pulse for 1 cycle, fetch at 0x100. Then pc at 32'hFFFF_FFFC → nextPC=0.
6. Assert RST low mid-wait with imem_req=1 → imem_req, ins_valid and fetch_cnt clear immediately. Fetch restarts at RESET_PC after release.
